// File: rtl/interval_timer_if.sv
// Signal bundle between the interval timer, its controlling FSM and the time-parameter store.
// The master modport is the environment side; the slave modport is the timer itself.
interface interval_timer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [1:0]       interval_sel;
    logic             oneHz_enable;
    logic             prog_sync;
    logic [1:0]       interval;
    logic [WIDTH-1:0] value;
    logic             expired;
    logic             busy;
    logic [WIDTH-1:0] remaining;

    modport master (
        output start, interval_sel, oneHz_enable, prog_sync, value,
        input  interval, expired, busy, remaining
    );

    modport slave (
        input  start, interval_sel, oneHz_enable, prog_sync, value,
        output interval, expired, busy, remaining
    );
endinterface

// File: rtl/interval_timer.sv
// Countdown timer: selects a duration from the time-parameter store, latches it after the
// store's read latency, counts 1 Hz ticks down to zero and pulses expired for one clock.
module interval_timer #(
    parameter int WIDTH     = 4,
    parameter int VALUE_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    interval_timer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2
    } state_t;

    localparam logic [1:0]       WAIT_INIT = 2'(VALUE_LAT - 1);
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

    state_t           r_state,    w_state_nxt;
    logic [1:0]       r_interval, w_interval_nxt;
    logic [1:0]       r_wait,     w_wait_nxt;
    logic [WIDTH-1:0] r_count,    w_count_nxt;
    logic             r_expired,  w_expired_nxt;
    logic [1:0]       w_sel_mapped;

    // The reserved select code reads the base interval.
    assign w_sel_mapped = (bus.interval_sel == 2'b11) ? 2'b00 : bus.interval_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_interval <= 2'b00;
            r_wait     <= 2'b00;
            r_count    <= '0;
            r_expired  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            r_state    <= w_state_nxt;
            r_interval <= w_interval_nxt;
            r_wait     <= w_wait_nxt;
            r_count    <= w_count_nxt;
            r_expired  <= w_expired_nxt;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path through the case infers a latch.
        w_state_nxt    = r_state;
        w_interval_nxt = r_interval;
        w_wait_nxt     = r_wait;
        w_count_nxt    = r_count;
        w_expired_nxt  = 1'b0;

        if (bus.prog_sync) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else if (bus.start) begin
            // Retrigger from any state: old count and any coincident expiry are discarded.
            w_state_nxt    = S_LOAD;
            w_interval_nxt = w_sel_mapped;
            w_wait_nxt     = WAIT_INIT;
            w_count_nxt    = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                end
                S_LOAD: begin
                    if (r_wait != 2'b00) begin
                        w_wait_nxt = r_wait - 2'd1;
                    end else if (bus.value == '0) begin
                        w_state_nxt   = S_IDLE;
                        w_expired_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_COUNT;
                        w_count_nxt = bus.value;
                    end
                end
                S_COUNT: begin
                    if (r_count == '0) begin
                        w_state_nxt = S_IDLE;
                    end else if (bus.oneHz_enable) begin
                        if (r_count == CNT_ONE) begin
                            w_state_nxt   = S_IDLE;
                            w_expired_nxt = 1'b1;
                            w_count_nxt   = '0;
                        end else begin
                            w_count_nxt = r_count - CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign bus.interval  = r_interval;
    assign bus.expired   = r_expired;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.remaining = r_count;
endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with a small time-parameter store model driving value.
module tb_interval_timer;
    localparam int WIDTH     = 4;
    localparam int VALUE_LAT = 1;

    typedef logic [7:0] obs_t;   // {interval, busy, expired, remaining}

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    interval_timer_if #(.WIDTH(WIDTH)) bus ();

    interval_timer #(.WIDTH(WIDTH), .VALUE_LAT(VALUE_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] store_base = 4'd0;
    logic [3:0] store_ext  = 4'd0;
    logic [3:0] store_yel  = 4'd0;

    always_comb begin
        case (bus.interval)
            2'b01:   bus.value = store_ext;
            2'b10:   bus.value = store_yel;
            default: bus.value = store_base;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic obs_t obs();
        return {bus.interval, bus.busy, bus.expired, bus.remaining};
    endfunction

    function automatic obs_t mk(input logic [1:0] iv, input logic b, input logic e,
                                input logic [3:0] r);
        return {iv, b, e, r};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sel);
        bus.start        = 1'b1;
        bus.interval_sel = sel;
        cycle();
        bus.start        = 1'b0;
    endtask

    task automatic do_tick();
        bus.oneHz_enable = 1'b1;
        cycle();
        bus.oneHz_enable = 1'b0;
    endtask

    task automatic test_reset();
        obs_t want;
        #2;
        want = mk(2'b00, 1'b0, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", obs(), want);
        end
        #10 rst_n = 1'b1;
        cycle();
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_basic();
        obs_t want;
        store_base = 4'd4;
        do_start(2'b00);
        want = mk(2'b00, 1'b1, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL basic_load: got %h want %h", obs(), want);
        end
        cycle();
        want = mk(2'b00, 1'b1, 1'b0, 4'd4);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL basic_latched: got %h want %h", obs(), want);
        end
        for (int k = 1; k <= 4; k++) begin
            repeat (9) cycle();
            want = mk(2'b00, 1'b1, 1'b0, 4'(5 - k));
            n_checks++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL basic_wait%0d: got %h want %h", k, obs(), want);
            end
            do_tick();
            want = (k < 4) ? mk(2'b00, 1'b1, 1'b0, 4'(4 - k)) : mk(2'b00, 1'b0, 1'b1, 4'd0);
            n_checks++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL basic_tick%0d: got %h want %h", k, obs(), want);
            end
        end
        cycle();
        want = mk(2'b00, 1'b0, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL basic_pulse_end: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_zero_length();
        obs_t want;
        store_yel = 4'd0;
        do_start(2'b10);
        want = mk(2'b10, 1'b1, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL zero_load: got %h want %h", obs(), want);
        end
        bus.oneHz_enable = 1'b1;
        cycle();
        bus.oneHz_enable = 1'b0;
        want = mk(2'b10, 1'b0, 1'b1, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL zero_expired: got %h want %h", obs(), want);
        end
        cycle();
        want = mk(2'b10, 1'b0, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL zero_hold: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_retrigger();
        obs_t want;
        store_base = 4'd6;
        store_ext  = 4'd3;
        do_start(2'b00);
        cycle();
        want = mk(2'b00, 1'b1, 1'b0, 4'd6);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL retrig_first: got %h want %h", obs(), want);
        end
        do_tick();
        cycle();
        do_tick();
        want = mk(2'b00, 1'b1, 1'b0, 4'd4);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL retrig_two_ticks: got %h want %h", obs(), want);
        end
        do_start(2'b01);
        want = mk(2'b01, 1'b1, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL retrig_reload: got %h want %h", obs(), want);
        end
        cycle();
        want = mk(2'b01, 1'b1, 1'b0, 4'd3);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL retrig_latched: got %h want %h", obs(), want);
        end
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            want = (k < 3) ? mk(2'b01, 1'b1, 1'b0, 4'(3 - k)) : mk(2'b01, 1'b0, 1'b1, 4'd0);
            n_checks++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL retrig_tick%0d: got %h want %h", k, obs(), want);
            end
        end
    endtask

    task automatic test_prog_sync();
        obs_t want;
        store_base = 4'd4;
        do_start(2'b00);
        cycle();
        do_tick();
        do_tick();
        want = mk(2'b00, 1'b1, 1'b0, 4'd2);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL psync_setup: got %h want %h", obs(), want);
        end
        bus.prog_sync    = 1'b1;
        bus.oneHz_enable = 1'b1;
        bus.start        = 1'b1;
        bus.interval_sel = 2'b10;
        cycle();
        bus.prog_sync    = 1'b0;
        bus.oneHz_enable = 1'b0;
        bus.start        = 1'b0;
        want = mk(2'b00, 1'b0, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL psync_abort: got %h want %h", obs(), want);
        end
        for (int k = 0; k < 4; k++) begin
            do_tick();
            n_checks++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL psync_quiet%0d: got %h want %h", k, obs(), want);
            end
        end
    endtask

    task automatic test_reserved_sel();
        obs_t want;
        store_base = 4'd1;
        store_ext  = 4'd9;
        store_yel  = 4'd9;
        do_start(2'b11);
        want = mk(2'b00, 1'b1, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL rsv_map: got %h want %h", obs(), want);
        end
        cycle();
        want = mk(2'b00, 1'b1, 1'b0, 4'd1);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL rsv_latched: got %h want %h", obs(), want);
        end
        do_tick();
        want = mk(2'b00, 1'b0, 1'b1, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL rsv_expired: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_back_to_back();
        obs_t want;
        store_base = 4'd2;
        store_ext  = 4'd3;
        do_start(2'b00);
        cycle();
        do_tick();
        want = mk(2'b00, 1'b1, 1'b0, 4'd1);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL b2b_setup: got %h want %h", obs(), want);
        end
        bus.start        = 1'b1;
        bus.interval_sel = 2'b01;
        bus.oneHz_enable = 1'b1;
        cycle();
        bus.start        = 1'b0;
        bus.oneHz_enable = 1'b0;
        want = mk(2'b01, 1'b1, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL b2b_no_expiry: got %h want %h", obs(), want);
        end
        cycle();
        want = mk(2'b01, 1'b1, 1'b0, 4'd3);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL b2b_reloaded: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_reset_mid_count();
        obs_t want;
        store_base = 4'd5;
        do_start(2'b00);
        cycle();
        want = mk(2'b00, 1'b1, 1'b0, 4'd5);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL rstmid_setup: got %h want %h", obs(), want);
        end
        rst_n            = 1'b0;
        bus.oneHz_enable = 1'b1;
        #1;
        want = mk(2'b00, 1'b0, 1'b0, 4'd0);
        n_checks++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h want %h", obs(), want);
        end
        cycle();
        #2 rst_n = 1'b1;
        bus.oneHz_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_tick();
            n_checks++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL rstmid_after%0d: got %h want %h", k, obs(), want);
            end
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.interval_sel = 2'b00;
        bus.oneHz_enable = 1'b0;
        bus.prog_sync    = 1'b0;
        test_reset();
        test_basic();
        test_zero_length();
        test_retrigger();
        test_prog_sync();
        test_reserved_sel();
        test_back_to_back();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
